// File: rtl/mini_src_mem_responder.sv
// Memory-side responder for the Mini SRC MAR/MDR bus: captures a Read or Write
// request, waits WAIT_CYCLES, performs one RAM access and completes with mem_done.
module mini_src_mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic [DATA_W-1:0] mdr_wdata,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mem_done,
  output logic              busy,
  output logic              err,
  output logic [1:0]        dbg_state_o
);

  // Handshake (4-phase): the requester raises exactly one of Read/Write and holds it;
  // mem_done rises once the access is complete and Mdatain is valid for a read;
  // the requester then drops both strobes and mem_done falls one edge later.
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              op_wr_q, op_wr_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic              in_range;
  logic [IDX_W-1:0]  ram_idx;

  logic [DATA_W-1:0] mem [DEPTH];

  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  assign ram_idx  = addr_q[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_wr_d = op_wr_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Read ^ Write) begin
          addr_d  = mar_addr;
          wdata_d = mdr_wdata;
          op_wr_d = Write;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_L;
          end else begin
            state_d = S_ACCESS;
          end
        end else if (Read && Write) begin
          err_d = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        state_d = S_DONE;
        err_d   = !in_range;
        if (op_wr_q) begin
          mem_we = in_range;
        end else begin
          rdata_d = in_range ? mem[ram_idx] : '0;
        end
      end
      S_DONE: begin
        if (!Read && !Write) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM is never cleared; clr at the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we && !clr) mem[ram_idx] <= wdata_q;
  end

  assign Mdatain     = rdata_q;
  assign mem_done    = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mini_src_mem_responder.sv
// Bench for mini_src_mem_responder: two instances (full-depth with one wait state,
// half-depth with none) share stimulus and are checked against a word-array model.
module tb_mini_src_mem_responder;

  logic        clk = 1'b0;
  logic        clr;
  logic [8:0]  mar_addr;
  logic [31:0] mdr_wdata;
  logic        Read, Write;
  logic [31:0] mdat1, mdat2;
  logic        done1, done2, busy1, busy2, err1, err2;
  logic [1:0]  dbg1, dbg2;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] model1 [512];
  logic [31:0] model2 [256];
  logic [8:0]  written[$];
  logic [31:0] exp1_q[$];
  logic [31:0] exp2_q[$];
  logic [31:0] last1 = 32'h0;
  logic [31:0] last2 = 32'h0;

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] data;
    int          hold;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  mini_src_mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .clr(clr), .mar_addr(mar_addr), .mdr_wdata(mdr_wdata),
    .Read(Read), .Write(Write), .Mdatain(mdat1), .mem_done(done1),
    .busy(busy1), .err(err1), .dbg_state_o(dbg1)
  );

  mini_src_mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(256), .WAIT_CYCLES(0)) dut2 (
    .clk(clk), .clr(clr), .mar_addr(mar_addr), .mdr_wdata(mdr_wdata),
    .Read(Read), .Write(Write), .Mdatain(mdat2), .mem_done(done2),
    .busy(busy2), .err(err2), .dbg_state_o(dbg2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge with both DUTs idle; returns at a negedge with both idle.
  task automatic do_access(input logic wr, input logic [8:0] addr, input logic [31:0] data,
                           input int hold);
    int          c;
    int          c2;
    logic        oor;
    logic [31:0] e1, e2;
    oor       = (addr >= 9'd256);
    Read      = ~wr;
    Write     = wr;
    mar_addr  = addr;
    mdr_wdata = data;
    if (wr) begin
      model1[addr] = data;
      if (!oor) model2[addr[7:0]] = data;
      written.push_back(addr);
    end else begin
      last1 = model1[addr];
      last2 = oor ? 32'h0 : model2[addr[7:0]];
    end
    exp1_q.push_back(last1);
    exp2_q.push_back(last2);
    c  = 0;
    c2 = 0;
    do begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        check("busy1_after_req", 32'(busy1), 32'd1);
        check("busy2_after_req", 32'(busy2), 32'd1);
        mar_addr  = addr + 9'd1;
        mdr_wdata = ~data;
      end
      if (c == 2) begin
        check("err1_no_pulse", 32'(err1), 32'd0);
        check("err2_oor_pulse", 32'(err2), 32'(oor));
      end
      if (c == 3) begin
        check("err1_done_entry", 32'(err1), 32'd0);
        check("err2_one_cycle", 32'(err2), 32'd0);
      end
      if (done2 && c2 == 0) c2 = c;
    end while (!done1 && c < 20);
    check("latency1", 32'(c), 32'd3);
    check("latency2", 32'(c2), 32'd2);
    e1 = exp1_q.pop_front();
    e2 = exp2_q.pop_front();
    check("mdat1", mdat1, e1);
    check("mdat2", mdat2, e2);
    check("done2_held", 32'(done2), 32'd1);
    repeat (hold) begin
      @(negedge clk);
      check("hold_done1", 32'(done1), 32'd1);
      check("hold_mdat1", mdat1, e1);
      check("hold_mdat2", mdat2, e2);
      mar_addr  = 9'($urandom);
      mdr_wdata = $urandom;
    end
    Read  = 1'b0;
    Write = 1'b0;
    @(negedge clk);
    check("release_done1", 32'(done1), 32'd0);
    check("release_busy1", 32'(busy1), 32'd0);
    check("release_done2", 32'(done2), 32'd0);
    check("release_busy2", 32'(busy2), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 9'h005, 32'h12345678, 0, 32'h00000000, 32'h00000000};
    vecs[1] = '{1'b0, 9'h005, 32'h00000000, 0, 32'h12345678, 32'h12345678};
    vecs[2] = '{1'b0, 9'h005, 32'h00000000, 6, 32'h12345678, 32'h12345678};
    vecs[3] = '{1'b1, 9'h010, 32'hAAAA0000, 2, 32'h12345678, 32'h12345678};
    vecs[4] = '{1'b1, 9'h1F0, 32'hCAFEF00D, 1, 32'h12345678, 32'h12345678};
    vecs[5] = '{1'b0, 9'h1F0, 32'h00000000, 0, 32'hCAFEF00D, 32'h00000000};
    vecs[6] = '{1'b1, 9'h0FF, 32'h0BADF00D, 0, 32'hCAFEF00D, 32'h00000000};
    vecs[7] = '{1'b0, 9'h0FF, 32'h00000000, 0, 32'h0BADF00D, 32'h0BADF00D};
    vecs[8] = '{1'b1, 9'h100, 32'h11111111, 3, 32'h0BADF00D, 32'h0BADF00D};
    vecs[9] = '{1'b0, 9'h100, 32'h00000000, 0, 32'h11111111, 32'h00000000};

    // Reset with Read asserted: nothing may start.
    clr = 1'b1; Read = 1'b1; Write = 1'b0; mar_addr = 9'h005; mdr_wdata = 32'h0;
    repeat (2) begin
      @(negedge clk);
      check("rst_mdat1", mdat1, 32'h0);
      check("rst_done1", 32'(done1), 32'd0);
      check("rst_busy1", 32'(busy1), 32'd0);
      check("rst_err1", 32'(err1), 32'd0);
      check("rst_busy2", 32'(busy2), 32'd0);
    end
    clr  = 1'b0;
    Read = 1'b0;
    @(negedge clk);
    check("post_rst_busy1", 32'(busy1), 32'd0);

    foreach (vecs[i]) begin
      do_access(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].hold);
      check($sformatf("vec%0d_mdat1", i), mdat1, vecs[i].exp1);
      check($sformatf("vec%0d_mdat2", i), mdat2, vecs[i].exp2);
    end

    // Illegal request: both strobes high for one edge.
    Read = 1'b1; Write = 1'b1; mar_addr = 9'h010; mdr_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("illegal_err1", 32'(err1), 32'd1);
    check("illegal_err2", 32'(err2), 32'd1);
    check("illegal_busy1", 32'(busy1), 32'd0);
    Read = 1'b0; Write = 1'b0;
    @(negedge clk);
    check("illegal_err1_clear", 32'(err1), 32'd0);
    check("illegal_busy1_after", 32'(busy1), 32'd0);
    do_access(1'b0, 9'h010, 32'h0, 0);
    check("illegal_readback", mdat1, 32'hAAAA0000);

    // clr while dut1 waits and dut2 is at its access edge aborts the write.
    Write = 1'b1; mar_addr = 9'h010; mdr_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    clr = 1'b1; Write = 1'b0;
    @(negedge clk);
    check("abort_busy1", 32'(busy1), 32'd0);
    check("abort_busy2", 32'(busy2), 32'd0);
    check("abort_mdat1", mdat1, 32'h0);
    check("abort_mdat2", mdat2, 32'h0);
    clr   = 1'b0;
    last1 = 32'h0;
    last2 = 32'h0;
    do_access(1'b0, 9'h010, 32'h0, 1);
    check("abort_readback1", mdat1, 32'hAAAA0000);
    check("abort_readback2", mdat2, 32'hAAAA0000);

    // Captured address: do_access moves mar_addr to 0x006 during the wait.
    do_access(1'b0, 9'h005, 32'h0, 0);
    check("captured_addr", mdat1, 32'h12345678);

    for (int n = 0; n < 40; n++) begin
      logic       wr;
      logic [8:0] a;
      wr = (written.size() == 0) || ($urandom_range(0, 1) == 1);
      a  = wr ? 9'($urandom_range(0, 511)) : written[$urandom_range(0, written.size() - 1)];
      do_access(wr, a, $urandom, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
